// File: rtl/third_step_if.sv
// EX stage port bundle: decoded operands in, EX/MEM results out.
// The stage itself connects through the slave modport.
interface third_step_if;
    logic        aluSrc;
    logic [5:0]  ALUOp;
    logic        regDst;
    logic [31:0] pcPlusFour;
    logic [31:0] reg1;
    logic [31:0] reg2;
    logic [31:0] signExtend;
    logic [4:0]  regDst1;
    logic [4:0]  regDst2;
    logic [31:0] addResult;
    logic        zero;
    logic [31:0] aluResult;
    logic [31:0] reg2Out;
    logic [4:0]  muxRegDstOut;

    modport master (
        output aluSrc, ALUOp, regDst, pcPlusFour,
        output reg1, reg2, signExtend, regDst1, regDst2,
        input  addResult, zero, aluResult, reg2Out, muxRegDstOut
    );

    modport slave (
        input  aluSrc, ALUOp, regDst, pcPlusFour,
        input  reg1, reg2, signExtend, regDst1, regDst2,
        output addResult, zero, aluResult, reg2Out, muxRegDstOut
    );
endinterface

// File: rtl/third_step.sv
// MIPS execute stage: branch target, ALU, dest-reg select.
// All results land in the EX/MEM register one clock later.
module third_step (
    input logic         clk,
    input logic         reset,
    third_step_if.slave bus
);
    logic [31:0] opA;
    logic [31:0] opB;
    logic [4:0]  shamt;
    logic [4:0]  varAmt;
    logic [31:0] aluNext;
    logic [31:0] addNext;
    logic [4:0]  dstNext;

    // operand selection and branch target
    always_comb begin
        opA     = bus.reg1;
        opB     = bus.aluSrc ? bus.signExtend : bus.reg2;
        shamt   = bus.signExtend[10:6];
        varAmt  = bus.reg1[4:0];
        addNext = bus.pcPlusFour + (bus.signExtend << 2);
        dstNext = bus.regDst ? bus.regDst2 : bus.regDst1;
    end

    // ALU operation decode on the funct code; unknown codes give 0
    always_comb begin
        aluNext = 32'h0;
        case (bus.ALUOp)
            6'b100000,
            6'b100001: aluNext = opA + opB;
            6'b100010,
            6'b100011: aluNext = opA - opB;
            6'b100100: aluNext = opA & opB;
            6'b100101: aluNext = opA | opB;
            6'b100110: aluNext = opA ^ opB;
            6'b100111: aluNext = ~(opA | opB);
            6'b101010: aluNext = {31'h0, $signed(opA) < $signed(opB)};
            6'b101011: aluNext = {31'h0, opA < opB};
            6'b000000: aluNext = opB << shamt;
            6'b000010: aluNext = opB >> shamt;
            6'b000011: aluNext = $signed(opB) >>> shamt;
            6'b000100: aluNext = opB << varAmt;
            6'b000110: aluNext = opB >> varAmt;
            6'b000111: aluNext = $signed(opB) >>> varAmt;
            6'b001111: aluNext = {opB[15:0], 16'h0};
            default:   aluNext = 32'h0;
        endcase
    end

    // EX/MEM register; reset drops any in-flight result
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bus.addResult    <= 32'h0;
            bus.zero         <= 1'b0;
            bus.aluResult    <= 32'h0;
            bus.reg2Out      <= 32'h0;
            bus.muxRegDstOut <= 5'h0;
        end else begin
            bus.addResult    <= addNext;
            bus.zero         <= (aluNext == 32'h0);
            bus.aluResult    <= aluNext;
            bus.reg2Out      <= bus.reg2;
            bus.muxRegDstOut <= dstNext;
        end
    end
endmodule

// File: tb/tb_third_step.sv
// Self-checking bench for the EX stage against a
// behavioural model of the MIPS funct semantics.
module tb_third_step;
    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    third_step_if bus();
    third_step dut (.clk(clk), .reset(reset), .bus(bus));

    int total = 0;
    int bad = 0;

    logic [31:0] eAdd;
    logic [31:0] eAlu;
    logic [31:0] eR2;
    logic        eZero;
    logic [4:0]  eDst;

    logic [5:0] opTab [18] = '{
        6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
        6'h2a, 6'h2b, 6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07,
        6'h0f, 6'h3f
    };

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] refAlu(logic [5:0] op,
                                           logic [31:0] a,
                                           logic [31:0] b,
                                           int sh);
        logic [31:0] p;
        logic [31:0] m;
        int s;
        s = (op == 6'h04 || op == 6'h06 || op == 6'h07) ? int'(a % 32) : sh;
        p = 32'd1 << s;
        m = 32'hFFFFFFFF / p;
        case (op)
            6'h20, 6'h21: return a + b;
            6'h22, 6'h23: return a - b;
            6'h24: return a & b;
            6'h25: return a | b;
            6'h26: return a ^ b;
            6'h27: return ~(a | b);
            6'h2a: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            6'h2b: return (a < b) ? 32'd1 : 32'd0;
            6'h00, 6'h04: return b * p;
            6'h02, 6'h06: return b / p;
            6'h03, 6'h07: return (b / p) | (b[31] ? ~m : 32'd0);
            6'h0f: return b * 32'd65536;
            default: return 32'd0;
        endcase
    endfunction

    task automatic setIn(logic src, logic [5:0] op, logic rd,
                         logic [31:0] pc, logic [31:0] r1,
                         logic [31:0] r2, logic [31:0] se,
                         logic [4:0] d1, logic [4:0] d2);
        logic [31:0] b;
        bus.aluSrc = src;
        bus.ALUOp = op;
        bus.regDst = rd;
        bus.pcPlusFour = pc;
        bus.reg1 = r1;
        bus.reg2 = r2;
        bus.signExtend = se;
        bus.regDst1 = d1;
        bus.regDst2 = d2;
        b = src ? se : r2;
        eAdd = pc + se * 32'd4;
        eAlu = refAlu(op, r1, b, int'(se / 64) % 32);
        eZero = (eAlu == 32'd0);
        eR2 = r2;
        eDst = rd ? d2 : d1;
    endtask

    task automatic setRand();
        logic [5:0] op;
        logic [15:0] imm;
        imm = 16'($urandom);
        if ($urandom_range(0, 7) == 0) op = 6'($urandom);
        else op = opTab[$urandom_range(0, 17)];
        setIn(1'($urandom), op, 1'($urandom), $urandom, $urandom,
              $urandom, {{16{imm[15]}}, imm}, 5'($urandom), 5'($urandom));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkAll(string tag);
        chk({tag, ".add"}, bus.addResult, eAdd);
        chk({tag, ".alu"}, bus.aluResult, eAlu);
        chk({tag, ".zero"}, 32'(bus.zero), 32'(eZero));
        chk({tag, ".r2"}, bus.reg2Out, eR2);
        chk({tag, ".dst"}, 32'(bus.muxRegDstOut), 32'(eDst));
    endtask

    task automatic checkZero(string tag);
        chk({tag, ".add"}, bus.addResult, 32'd0);
        chk({tag, ".alu"}, bus.aluResult, 32'd0);
        chk({tag, ".zero"}, 32'(bus.zero), 32'd0);
        chk({tag, ".r2"}, bus.reg2Out, 32'd0);
        chk({tag, ".dst"}, 32'(bus.muxRegDstOut), 32'd0);
    endtask

    logic [5:0]  dOp  [7] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2a, 6'h2b, 6'h07};
    logic [31:0] dExp [7] = '{32'h80000005, 32'h80000003, 32'h0,
                              32'h80000005, 32'h0, 32'h1, 32'hF8000000};

    initial begin
        logic [31:0] oldAlu;
        logic [31:0] oldAdd;
        setIn(0, 6'h00, 1, 32'd99, 32'd1, 32'd2, 32'd3, 5'd4, 5'd6);
        repeat (3) tick();
        checkZero("rst");

        setIn(0, 6'h00, 1, 32'd32, 32'd4, 32'h80000001, 32'd25, 5'd5, 5'd8);
        reset = 1'b1;
        tick();
        chk("rel.add", bus.addResult, 32'd132);
        chk("rel.alu", bus.aluResult, 32'h80000001);
        chk("rel.zero", 32'(bus.zero), 32'd0);
        chk("rel.r2", bus.reg2Out, 32'h80000001);
        chk("rel.dst", 32'(bus.muxRegDstOut), 32'd8);

        setIn(0, 6'h00, 1, 32'd32, 32'd4, 32'h80000001, 32'd7, 5'd5, 5'd8);
        tick();
        chk("se7.add", bus.addResult, 32'd60);
        setIn(0, 6'h00, 0, 32'd32, 32'd4, 32'h80000001, 32'd7, 5'd5, 5'd8);
        tick();
        chk("rd0.dst", 32'(bus.muxRegDstOut), 32'd5);

        for (int i = 0; i < 7; i++) begin
            setIn(0, dOp[i], 1, 32'd32, 32'd4, 32'h80000001, 32'd0, 5'd5, 5'd8);
            tick();
            chk($sformatf("dir%0d.alu", i), bus.aluResult, dExp[i]);
            chk($sformatf("dir%0d.zero", i), 32'(bus.zero),
                (dExp[i] == 32'd0) ? 32'd1 : 32'd0);
        end

        setIn(1, 6'h20, 1, 32'd100, 32'd4, 32'd9, 32'hFFFFFFFC, 5'd5, 5'd8);
        tick();
        chk("imm.alu", bus.aluResult, 32'd0);
        chk("imm.zero", 32'(bus.zero), 32'd1);
        chk("imm.add", bus.addResult, 32'd84);

        setIn(0, 6'h3f, 1, 32'd100, 32'd4, 32'd9, 32'd1, 5'd5, 5'd8);
        tick();
        chk("undef.alu", bus.aluResult, 32'd0);
        chk("undef.zero", 32'(bus.zero), 32'd1);

        setIn(0, 6'h25, 1, 32'd100, 32'd4, 32'd9, 32'd1, 5'd5, 5'd8);
        tick();
        checkAll("pre");
        oldAlu = eAlu;
        oldAdd = eAdd;
        setIn(0, 6'h20, 1, 32'd500, 32'd7, 32'd11, 32'd2, 5'd5, 5'd8);
        #2;
        chk("hold.alu", bus.aluResult, oldAlu);
        chk("hold.add", bus.addResult, oldAdd);
        tick();
        checkAll("lat");

        #2;
        reset = 1'b0;
        #1;
        checkZero("async");
        tick();
        checkZero("rsthold");
        setIn(0, 6'h22, 1, 32'd40, 32'd50, 32'd8, 32'd3, 5'd1, 5'd2);
        reset = 1'b1;
        tick();
        checkAll("rerel");

        for (int i = 0; i < 400; i++) begin
            setRand();
            tick();
            checkAll("rnd");
            if ((i % 16) == 0) begin
                oldAlu = eAlu;
                setRand();
                #2;
                chk("rndhold", bus.aluResult, oldAlu);
                tick();
                checkAll("rndlat");
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/third_step.md
Name: third_step

Overview:
- Execute (EX) stage of the 5-stage MIPS pipeline.
- Computes the branch target, selects ALU operand B, performs the ALU operation selected by ALUOp, flags a zero result, forwards reg2 for stores, and selects the destination register.
- All results are captured in an internal EX/MEM output register, so outputs appear one clock after inputs.

Parameters:
- None. Data width is fixed at 32 bits; register-address width is fixed at 5 bits.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- aluSrc  in  1  0: ALU B = reg2; 1: ALU B = signExtend
- ALUOp  in  6  ALU operation select (MIPS funct encoding)
- regDst  in  1  0: dest = regDst1 (rt); 1: dest = regDst2 (rd)
- pcPlusFour  in  32  PC+4 of the instruction
- reg1  in  32  rs operand (ALU A), signed
- reg2  in  32  rt operand, signed
- signExtend  in  32  sign-extended immediate
- regDst1  in  5  rt field
- regDst2  in  5  rd field
- addResult  out  32  branch target
- zero  out  1  ALU result equals 0
- aluResult  out  32  ALU result
- reg2Out  out  32  reg2 passthrough
- muxRegDstOut  out  5  selected destination register

Behaviour:
- Reset (reset=0, asynchronous): all outputs go to 0 immediately and stay 0 while reset is low.
- Each rising clk with reset=1 registers all outputs from the current inputs. Latency is 1 cycle; a new result is produced every cycle. There is no handshake and no stall input.
- addResult = pcPlusFour + (signExtend << 2), modulo 2^32.
- B = aluSrc ? signExtend : reg2. A = reg1.
- shamt = signExtend[10:6].
- ALUOp decode:
  - 100000 ADD, 100001 ADDU: A+B, wraps.
  - 100010 SUB, 100011 SUBU: A-B, wraps.
  - 100100 AND, 100101 OR, 100110 XOR, 100111 NOR (~(A|B)).
  - 101010 SLT: signed A<B gives 1, else 0.
  - 101011 SLTU: unsigned compare, same result encoding.
  - 000000 SLL: B<<shamt.
  - 000010 SRL: B>>shamt (logical).
  - 000011 SRA: B>>>shamt (arithmetic).
  - 000100 SLLV: B<<A[4:0].
  - 000110 SRLV: B>>A[4:0] (logical).
  - 000111 SRAV: B>>>A[4:0] (arithmetic).
  - 001111 LUI: {B[15:0],16'h0}.
  - Any other code: result 0.
- Arithmetic overflow is ignored: no trap and no flag.
- zero = (ALU result == 0). It is computed from the same-cycle result and registered with it. An undefined ALUOp therefore gives zero=1.
- reg2Out = reg2, unaffected by aluSrc.
- muxRegDstOut = regDst ? regDst2 : regDst1.
- Input changes between clock edges do not affect outputs until the next edge.
- Reset asserted mid-stream discards the in-flight result. The first edge after release registers the current inputs.

Test Plan:
- Reset: hold reset=0 and toggle clk → all outputs 0. Release reset with inputs pcPlusFour=32, reg1=4, reg2=32'h80000001, signExtend=25, aluSrc=0, ALUOp=0, regDst=1, regDst1=5, regDst2=8. After one edge → addResult=132, aluResult=32'h80000001 (SLL by shamt 0), zero=0, reg2Out=32'h80000001, muxRegDstOut=8.
- Same inputs, then signExtend=7 → after the next edge addResult=60. Set regDst=0 → muxRegDstOut=5.
- ALU ops with reg1=4, reg2=32'h80000001, aluSrc=0:
  - ADD → 32'h80000005.
  - SUB → 32'h80000003.
  - AND → 0, zero=1.
  - OR → 32'h80000005.
  - SLT → 0 (4 is not less than a negative number).
  - SLTU → 1.
  - SRAV → 32'hF8000000.
- aluSrc=1, signExtend=32'hFFFFFFFC, reg1=4, ALUOp=ADD → aluResult=0, zero=1. Same signExtend gives addResult = pcPlusFour - 16.
- Latency and async reset: verify outputs change only on the edge after an input change. Assert reset between edges → outputs clear without waiting for clk.
- ALUOp=6'b111111 → aluResult=0, zero=1.
